// File: rtl/prbs31_128bit_chk_if.sv
// Bus bundle for the 128-bit PRBS31 receive checker.
// Handshake: din_vld qualifies din for exactly one clk cycle. There is no
// ready/backpressure; the checker consumes every cycle where din_vld=1, and
// cycles with din_vld=0 carry no data. cnt_clr is a level-sampled,
// single-cycle synchronous clear.
// dbg_state exposes the checker FSM (0=HUNT, 1=VERIFY, 2=LOCKED).
interface prbs31_128bit_chk_if #(
    parameter int CNT_W = 32
);
    logic             din_vld;
    logic [127:0]     din;
    logic             cnt_clr;
    logic             locked;
    logic             err_flag;
    logic             lock_lost;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_err_cnt;
    logic [CNT_W-1:0] bit_err_cnt;
    logic [1:0]       dbg_state;

    // Data source / status reader side
    modport master (
        output din_vld,
        output din,
        output cnt_clr,
        input  locked,
        input  err_flag,
        input  lock_lost,
        input  word_cnt,
        input  word_err_cnt,
        input  bit_err_cnt,
        input  dbg_state
    );

    // Checker side
    modport slave (
        input  din_vld,
        input  din,
        input  cnt_clr,
        output locked,
        output err_flag,
        output lock_lost,
        output word_cnt,
        output word_err_cnt,
        output bit_err_cnt,
        output dbg_state
    );
endinterface

// File: rtl/prbs31_128bit_chk.sv
// Receive-side checker for the 128-bit inverted PRBS31 stream
// (b[n] = ~(b[n-28] ^ b[n-31]), din[127] oldest bit, din[0] newest).
// Self-synchronises in HUNT, confirms in VERIFY, then counts word/bit errors
// while LOCKED. The predictor free-runs once locked so line errors never
// corrupt it.
// Build option: define PRBS_CHK_BITCNT_EN to add the popcount stage and a
// live bit_err_cnt (err_flag/counters then lag the accepting edge by 2
// cycles). Without it bit_err_cnt reads 0 and err_flag/counters lag by 1.
// Counters assume CNT_W >= 8 so one word's bit count (0..128) fits.
module prbs31_128bit_chk #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 8,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rstn,
    prbs31_128bit_chk_if.slave io_bus
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]       LP_LOCK_CNT   = 8'(LOCK_CNT);
    localparam logic [7:0]       LP_UNLOCK_CNT = 8'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] LP_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // The 128 bits following a word depend only on its newest 31 bits.
    // e[158:128] holds that history, e[127:0] the generated word.
    function automatic logic [127:0] prbs_next(input logic [30:0] tail);
        logic [158:0] e;
        e          = '0;
        e[158:128] = tail;
        for (int j = 127; j >= 0; j--) begin
            e[j] = ~(e[j+28] ^ e[j+31]);
        end
        return e[127:0];
    endfunction

    // Every bit with a full 31-bit history inside the word obeys the recurrence.
    function automatic logic word_consistent(input logic [127:0] w);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j <= 96; j++) begin
            if (w[j] != ~(w[j+28] ^ w[j+31])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser FSM and predictor
    // ------------------------------------------------------------------
    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_pred;
    logic [127:0] w_pred_nxt;
    logic [7:0]   r_match_run;
    logic [7:0]   w_match_run_nxt;
    logic [7:0]   r_miss_run;
    logic [7:0]   w_miss_run_nxt;
    logic         w_lock_lost_set;

    logic [127:0] w_pred_adv;
    logic [127:0] w_pred_seed;
    logic         w_din_ok;
    logic         w_mismatch;
    logic         w_match_done;
    logic         w_miss_done;

    assign w_pred_adv   = prbs_next(r_pred[30:0]);
    assign w_pred_seed  = prbs_next(io_bus.din[30:0]);
    // The all-ones word satisfies the XNOR recurrence but is the lockup state.
    assign w_din_ok     = word_consistent(io_bus.din) && (io_bus.din != {128{1'b1}});
    assign w_mismatch   = (io_bus.din != r_pred);
    assign w_match_done = ((r_match_run + 8'd1) == LP_LOCK_CNT);
    assign w_miss_done  = ((r_miss_run + 8'd1) == LP_UNLOCK_CNT);

    // FSM state, predictor and run counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_HUNT;
            r_pred      <= '0;
            r_match_run <= '0;
            r_miss_run  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_match_run <= w_match_run_nxt;
            r_miss_run  <= w_miss_run_nxt;
        end
    end

    // Next-state decode; idle cycles leave everything untouched
    always_comb begin
        w_state_nxt     = r_state;
        w_pred_nxt      = r_pred;
        w_match_run_nxt = r_match_run;
        w_miss_run_nxt  = r_miss_run;
        w_lock_lost_set = 1'b0;
        if (io_bus.din_vld) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_din_ok) begin
                        w_pred_nxt      = w_pred_seed;
                        w_match_run_nxt = '0;
                        w_state_nxt     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (!w_mismatch) begin
                        w_pred_nxt = w_pred_adv;
                        if (w_match_done) begin
                            w_state_nxt     = ST_LOCKED;
                            w_match_run_nxt = '0;
                            w_miss_run_nxt  = '0;
                        end else begin
                            w_match_run_nxt = r_match_run + 8'd1;
                        end
                    end else begin
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    w_pred_nxt = w_pred_adv;
                    if (w_mismatch) begin
                        if (w_miss_done) begin
                            w_state_nxt     = ST_HUNT;
                            w_miss_run_nxt  = '0;
                            w_lock_lost_set = 1'b1;
                        end else begin
                            w_miss_run_nxt = r_miss_run + 8'd1;
                        end
                    end else begin
                        w_miss_run_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture the comparison of each word accepted while LOCKED
    // ------------------------------------------------------------------
    logic r_s1_vld;
`ifdef PRBS_CHK_BITCNT_EN
    logic [127:0] r_s1_diff;

    // Register valid flag and the full error vector
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld  <= 1'b0;
            r_s1_diff <= '0;
        end else begin
            r_s1_vld  <= io_bus.din_vld && (r_state == ST_LOCKED);
            r_s1_diff <= io_bus.din ^ r_pred;
        end
    end
`else
    logic r_s1_err;

    // Register valid flag and the word-level mismatch only
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld <= 1'b0;
            r_s1_err <= 1'b0;
        end else begin
            r_s1_vld <= io_bus.din_vld && (r_state == ST_LOCKED);
            r_s1_err <= w_mismatch;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage 2 (bit counting builds only): popcount of the error vector
    // ------------------------------------------------------------------
    logic       w_acc_vld;
    logic       w_acc_err;
`ifdef PRBS_CHK_BITCNT_EN
    function automatic logic [7:0] popcount128(input logic [127:0] v);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < 128; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

    logic [7:0] w_s1_popcnt;
    logic       r_s2_vld;
    logic       r_s2_err;
    logic [7:0] r_s2_popcnt;

    assign w_s1_popcnt = popcount128(r_s1_diff);

    // Register the per-word bit-error count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_vld    <= 1'b0;
            r_s2_err    <= 1'b0;
            r_s2_popcnt <= '0;
        end else begin
            r_s2_vld    <= r_s1_vld;
            r_s2_err    <= (w_s1_popcnt != 8'd0);
            r_s2_popcnt <= w_s1_popcnt;
        end
    end

    assign w_acc_vld = r_s2_vld;
    assign w_acc_err = r_s2_err;
`else
    assign w_acc_vld = r_s1_vld;
    assign w_acc_err = r_s1_err;
`endif

    // ------------------------------------------------------------------
    // Accumulation: saturating statistics, cnt_clr beats increments
    // ------------------------------------------------------------------
    logic             r_err_flag;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_word_err_cnt;
    logic [CNT_W-1:0] w_word_cnt_inc;
    logic [CNT_W-1:0] w_word_err_inc;

    assign w_word_cnt_inc = (&r_word_cnt)     ? r_word_cnt     : r_word_cnt + LP_CNT_ONE;
    assign w_word_err_inc = (&r_word_err_cnt) ? r_word_err_cnt : r_word_err_cnt + LP_CNT_ONE;

    // Error pulse and word counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_flag     <= 1'b0;
            r_word_cnt     <= '0;
            r_word_err_cnt <= '0;
        end else begin
            r_err_flag <= w_acc_vld && w_acc_err;
            if (io_bus.cnt_clr) begin
                r_word_cnt     <= '0;
                r_word_err_cnt <= '0;
            end else if (w_acc_vld) begin
                r_word_cnt <= w_word_cnt_inc;
                if (w_acc_err) begin
                    r_word_err_cnt <= w_word_err_inc;
                end
            end
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    logic [CNT_W-1:0] r_bit_err_cnt;
    logic [CNT_W:0]   w_bit_sum;

    assign w_bit_sum = {1'b0, r_bit_err_cnt} + {{(CNT_W-7){1'b0}}, r_s2_popcnt};

    // Bit-error accumulator, clamped at all-ones on overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bit_err_cnt <= '0;
        end else if (io_bus.cnt_clr) begin
            r_bit_err_cnt <= '0;
        end else if (w_acc_vld && w_acc_err) begin
            r_bit_err_cnt <= w_bit_sum[CNT_W] ? {CNT_W{1'b1}} : w_bit_sum[CNT_W-1:0];
        end
    end

    assign io_bus.bit_err_cnt = r_bit_err_cnt;
`else
    assign io_bus.bit_err_cnt = '0;
`endif

    // ------------------------------------------------------------------
    // Sticky loss-of-lock flag: a new loss wins over a same-cycle clear
    // ------------------------------------------------------------------
    logic r_lock_lost;

    // Set on LOCKED->HUNT, cleared by cnt_clr
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lock_lost <= 1'b0;
        end else if (w_lock_lost_set) begin
            r_lock_lost <= 1'b1;
        end else if (io_bus.cnt_clr) begin
            r_lock_lost <= 1'b0;
        end
    end

    assign io_bus.locked       = (r_state == ST_LOCKED);
    assign io_bus.err_flag     = r_err_flag;
    assign io_bus.lock_lost    = r_lock_lost;
    assign io_bus.word_cnt     = r_word_cnt;
    assign io_bus.word_err_cnt = r_word_err_cnt;
    assign io_bus.dbg_state    = r_state;

endmodule
